membus_uart_tx: RTL and testbench
=================================

Name: membus_uart_tx

Overview:
- Memory-bus responder that hangs on the CPU data bus beside the data memory and decodes its own address window.
- Accepts bytes written by the CPU into a small FIFO and serializes them as 8N1 UART frames on a single TX pin.
- Exposes a status register so firmware can poll busy, full, empty and overflow.

Parameters:
- BASE_ADDR, 32'h4000_0018, byte address of TXDATA; STATUS is at BASE_ADDR+4.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Address  in  32  byte address from the CPU memory bus
- Write_data  in  32  write data; bits [7:0] are used
- MemRead  in  1  read strobe
- MemWrite  in  1  write strobe, sampled at the rising edge of clk
- Read_data  out  32  read data, combinational
- tx  out  1  UART serial output, idle high

Behaviour:
- Reset (asynchronous, active-high):
  - tx=1, FSM=IDLE, FIFO empty, overflow flag=0.
  - Bit and cycle counters=0.
  - Read_data=0.
- Address decode: full 32-bit compare against BASE_ADDR (TXDATA) and BASE_ADDR+4 (STATUS). Any other address is not claimed: Read_data=0 and writes are ignored.
- Read path (combinational):
  - When MemRead=1 and Address=STATUS: Read_data = {27'b0, overflow, full, empty, busy, 1'b0}... precisely, bit0=busy (FSM != IDLE), bit1=full, bit2=empty, bit3=overflow, [31:4]=0.
  - Reading TXDATA returns 0.
  - MemRead=0 drives Read_data=0.
- Write path, sampled at posedge clk:
  - MemWrite=1 at TXDATA pushes Write_data[7:0].
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and overflow is set (sticky).
  - MemWrite=1 at STATUS clears overflow. Write data is ignored.
- FIFO: circular buffer with read/write pointers and a count.
  - Simultaneous push and pop: both are performed, count unchanged. This holds even when the FIFO is full, so no overflow is flagged.
  - Pointers wrap modulo FIFO_DEPTH.
- Transmit FSM (one state held per bit period, CLKS_PER_BIT cycles each):
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. At the end of each bit period, shift right; after the 8th bit, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Latency and timing:
  - Write to empty FIFO with FSM idle: start bit appears on tx 2 clocks after the write edge (push, then pop).
  - Frame length = 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly 1 IDLE cycle between the stop bit and the next start bit.
- tx is driven from a register, so there are no combinational glitches.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). Any queued bytes are discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for one bit period.
  - Frame = 11*CLKS_PER_BIT cycles.
  - STATUS bit4 reads 1 to advertise parity.
- Undefined:
  - No PARITY state; 8N1 framing.
  - STATUS bit4 reads 0.

Test Plan:
- Reset with CLKS_PER_BIT=4, no writes -> tx=1 constantly; STATUS read returns 32'h0000_0004 (empty only).
- Write 32'h0000_00A5 to 0x4000_0018 -> start bit 2 clocks later, then tx shows bits 1,0,1,0,0,1,0,1 (4 clocks each), then stop 1. STATUS bit0=1 during the frame and 0 afterwards; frame spans 40 clocks.
- Five back-to-back writes 0x11..0x15 with FIFO_DEPTH=4, written while the first frame is still queued -> exactly the first five bytes are transmitted in order when one pop overlaps, otherwise 0x15 is dropped and STATUS bit3=1. Check both timings. A subsequent write to STATUS clears bit3.
- Write to full FIFO in the exact cycle the FSM pops -> byte accepted, overflow stays 0, all bytes transmitted in order.
- Assert reset during bit 3 of a frame with 2 bytes queued -> tx=1 within the same cycle; STATUS=32'h0000_0004 after release; no further frames are transmitted.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit=1, frame=44 clocks, STATUS bit4=1. Without the macro, STATUS bit4=0 and frame=40 clocks.

Source files
------------

// File: rtl/membus_uart_tx.sv
// membus_uart_tx: memory-bus mapped UART transmitter.
// TXDATA at BASE_ADDR pushes a byte into a small FIFO; STATUS at BASE_ADDR+4 reports
// {parity_en, overflow, full, empty, busy}. Frames are 8N1 by default.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module membus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        tx
);

  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] StatusAddr = BASE_ADDR + 32'd4;
  localparam logic [15:0] BitEnd     = 16'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic ParityEn = 1'b1;
`else
  localparam logic ParityEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            empty, full, wr_txdata, wr_status, push_ok, pop;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_end;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Only the low byte of a TXDATA write is meaningful.
  logic unused_wdata;
  assign unused_wdata = ^Write_data[31:8];

  assign empty     = (count_q == '0);
  assign full      = (count_q == CountFull);
  assign wr_txdata = MemWrite && (Address == BASE_ADDR);
  assign wr_status = MemWrite && (Address == StatusAddr);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = wr_txdata && (!full || pop);
  assign bit_end   = (cnt_q == BitEnd);
  assign tx        = tx_q;

  // FIFO storage; no reset needed since count_q defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= Write_data[7:0];
  end

  // FIFO occupancy and sticky overflow next-state.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q;
    if (wr_status) begin
      overflow_d = 1'b0;
    end else if (wr_txdata && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  // FIFO pointers, count and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Transmit FSM next-state; tx_d reflects the current state so tx lags state by one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    tx_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = fifo_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_q[rd_ptr_q];
`endif
          cnt_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StParity: begin
`ifdef UART_TX_PARITY_EN
        tx_d = parity_q;
`endif
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Transmit FSM state, counters, shift register and registered tx pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Combinational read path; only STATUS returns non-zero data.
  always_comb begin
    Read_data = '0;
    if (MemRead && (Address == StatusAddr)) begin
      Read_data[0] = (state_q != StIdle);
      Read_data[1] = full;
      Read_data[2] = empty;
      Read_data[3] = overflow_q;
      Read_data[4] = ParityEn;
    end
  end

endmodule

// File: tb/tb_membus_uart_tx.sv
// Bench for membus_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A tx monitor decodes frames into rx_q; tests push expected bytes into exp_q and compare.
`timescale 1ns/1ps
module tb_membus_uart_tx;

  localparam logic [31:0] Base = 32'h4000_0018;
  localparam logic [31:0] Stat = 32'h4000_001C;
  localparam int Cpb = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          Nb  = 11;
  localparam logic [31:0] Par = 32'h10;
`else
  localparam int          Nb  = 10;
  localparam logic [31:0] Par = 32'h0;
`endif
  localparam int FrameGap = Nb * Cpb + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        tx;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wr = 0;
  int n_starts = 0;
  bit rst_seen = 1'b0;

  logic [7:0]  exp_q[$];
  logic [10:0] rx_q[$];
  int          rx_start_q[$];

  membus_uart_tx #(
    .BASE_ADDR   (Base),
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .Write_data(Write_data),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Read_data (Read_data),
    .tx        (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge reset) rst_seen = 1'b1;

  // Frame monitor: samples every negedge, requires each bit constant for Cpb cycles.
  initial begin : monitor
    int          st;
    logic [10:0] fr;
    logic        shape_ok;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        st = cyc; n_starts++; rst_seen = 1'b0; shape_ok = 1'b1; fr = '0;
        for (int b = 0; b < Nb; b++) begin
          for (int k = 0; k < Cpb; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (k == 0) fr[b] = tx;
            else if (tx !== fr[b]) shape_ok = 1'b0;
          end
        end
        if (!rst_seen) begin
          n_vec++;
          if (!shape_ok || fr[0] !== 1'b0 || fr[Nb-1] !== 1'b1) begin
            n_err++;
            $display("FAIL frame_shape: start=%0d got bits=%b stable=%0b, required start 0 stop 1 stable 1",
                     st, fr, shape_ok);
          end
          rx_q.push_back(fr);
          rx_start_q.push_back(st);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Address = a; Write_data = d; MemWrite = 1'b1;
    @(negedge clk);
    last_wr = cyc;
    MemWrite = 1'b0; Address = '0; Write_data = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Address = a; MemRead = 1'b1;
    #1;
    d = Read_data;
    MemRead = 1'b0; Address = '0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit timed_out);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    timed_out = (rx_q.size() < n);
  endtask

  task automatic test_reset();
    int bad = 0;
    logic [31:0] r;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b, required 1", tx); end
    n_vec++;
    if (Read_data !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h, required 0", Read_data);
    end
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL idle_tx: got %0d low cycles, required 0", bad); end
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h4 | Par)) begin
      n_err++; $display("FAIL status_reset: got %h, required %h", r, 32'h4 | Par);
    end
  endtask

  task automatic test_decode();
    logic [31:0] r;
    int n0;
    bus_read(Base, r);
    n_vec++;
    if (r !== 32'h0) begin n_err++; $display("FAIL read_txdata: got %h, required 0", r); end
    Address = Stat; MemRead = 1'b0;
    #1;
    n_vec++;
    if (Read_data !== 32'h0) begin
      n_err++; $display("FAIL read_nostrobe: got %h, required 0", Read_data);
    end
    Address = '0;
    n0 = n_starts;
    bus_write(Base + 32'd8, 32'h55);
    bus_write(Base - 32'd4, 32'h55);
    repeat (60) @(negedge clk);
    n_vec++;
    if (n_starts != n0) begin
      n_err++; $display("FAIL unclaimed_write: got %0d frames, required 0", n_starts - n0);
    end
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h4 | Par)) begin
      n_err++; $display("FAIL status_unclaimed: got %h, required %h", r, 32'h4 | Par);
    end
  endtask

  task automatic test_single();
    logic [31:0] r;
    logic [10:0] got;
    int st, w;
    bit to;
    exp_q.push_back(8'hA5);
    bus_write(Base, 32'h0000_00A5);
    w = last_wr;
    repeat (10) @(negedge clk);
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h5 | Par)) begin
      n_err++; $display("FAIL status_busy: got %h, required %h", r, 32'h5 | Par);
    end
    wait_rx(1, 100, to);
    n_vec++;
    if (to) begin
      n_err++; $display("FAIL single_timeout: got 0 frames, required 1"); exp_q.delete();
    end else begin
      got = rx_q.pop_front(); st = rx_start_q.pop_front();
      n_vec++;
      if (got[8:1] !== exp_q.pop_front()) begin
        n_err++; $display("FAIL single_data: got %h, required a5", got[8:1]);
      end
      n_vec++;
      if (st != w + 2) begin n_err++; $display("FAIL start_latency: got %0d, required %0d", st, w + 2); end
    end
    repeat (2) @(negedge clk);
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h4 | Par)) begin
      n_err++; $display("FAIL status_after: got %h, required %h", r, 32'h4 | Par);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [10:0] got;
    int st, w0;
    bit to;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h11 + i));
      bus_write(Base, 32'(8'h11 + i));
      if (i == 0) w0 = last_wr;
    end
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h3 | Par)) begin
      n_err++; $display("FAIL b2b_status: got %h, required %h", r, 32'h3 | Par);
    end
    wait_rx(5, 5 * FrameGap + 60, to);
    n_vec++;
    if (to) begin
      n_err++; $display("FAIL b2b_timeout: got %0d frames, required 5", rx_q.size());
      exp_q.delete(); rx_q.delete(); rx_start_q.delete();
    end else begin
      for (int i = 0; i < 5; i++) begin
        got = rx_q.pop_front(); st = rx_start_q.pop_front();
        n_vec++;
        if (got[8:1] !== exp_q.pop_front()) begin
          n_err++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, got[8:1], 8'(8'h11 + i));
        end
        n_vec++;
        if (st != w0 + 2 + i * FrameGap) begin
          n_err++; $display("FAIL b2b_start[%0d]: got %0d, required %0d", i, st, w0 + 2 + i * FrameGap);
        end
      end
    end
    repeat (2) @(negedge clk);
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h4 | Par)) begin
      n_err++; $display("FAIL b2b_status_end: got %h, required %h", r, 32'h4 | Par);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [10:0] got;
    logic [7:0]  e;
    bit to;
    exp_q.push_back(8'h10);
    bus_write(Base, 32'h10);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'(8'h11 + i));
      bus_write(Base, 32'(8'h11 + i));
    end
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'hB | Par)) begin
      n_err++; $display("FAIL ovf_status: got %h, required %h", r, 32'hB | Par);
    end
    bus_write(Stat, 32'hFFFF_FFFF);
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h3 | Par)) begin
      n_err++; $display("FAIL ovf_clear: got %h, required %h", r, 32'h3 | Par);
    end
    wait_rx(5, 5 * FrameGap + 60, to);
    n_vec++;
    if (to) begin
      n_err++; $display("FAIL ovf_timeout: got %0d frames, required 5", rx_q.size());
      exp_q.delete(); rx_q.delete(); rx_start_q.delete();
    end else begin
      for (int i = 0; i < 5; i++) begin
        got = rx_q.pop_front(); void'(rx_start_q.pop_front()); e = exp_q.pop_front();
        n_vec++;
        if (got[8:1] !== e) begin
          n_err++; $display("FAIL ovf_data[%0d]: got %h, required %h", i, got[8:1], e);
        end
      end
    end
    repeat (FrameGap) @(negedge clk);
    n_vec++;
    if (rx_q.size() != 0) begin
      n_err++; $display("FAIL ovf_dropped: got %0d extra frames, required 0", rx_q.size());
      rx_q.delete(); rx_start_q.delete();
    end
  endtask

  task automatic test_push_on_pop();
    logic [31:0] r;
    logic [10:0] got;
    logic [7:0]  e;
    int w;
    bit to;
    exp_q.push_back(8'h20);
    bus_write(Base, 32'h20);
    w = last_wr;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h21 + i));
      bus_write(Base, 32'(8'h21 + i));
    end
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h3 | Par)) begin
      n_err++; $display("FAIL pop_full: got %h, required %h", r, 32'h3 | Par);
    end
    // Next pop edge is the one after which cyc == w + 2 + Nb*Cpb.
    while (cyc < w + 1 + Nb * Cpb) @(negedge clk);
    exp_q.push_back(8'h25);
    bus_write(Base, 32'h25);
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h3 | Par)) begin
      n_err++; $display("FAIL pop_push_status: got %h, required %h", r, 32'h3 | Par);
    end
    wait_rx(6, 6 * FrameGap + 60, to);
    n_vec++;
    if (to) begin
      n_err++; $display("FAIL pop_timeout: got %0d frames, required 6", rx_q.size());
      exp_q.delete(); rx_q.delete(); rx_start_q.delete();
    end else begin
      for (int i = 0; i < 6; i++) begin
        got = rx_q.pop_front(); void'(rx_start_q.pop_front()); e = exp_q.pop_front();
        n_vec++;
        if (got[8:1] !== e) begin
          n_err++; $display("FAIL pop_data[%0d]: got %h, required %h", i, got[8:1], e);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_parity();
    logic [31:0] r;
    logic [10:0] got;
    bit to;
    bus_read(Stat, r);
    n_vec++;
    if ((r & 32'h10) !== Par) begin
      n_err++; $display("FAIL parity_status: got %h, required %h", r & 32'h10, Par);
    end
    bus_write(Base, 32'h07);
    wait_rx(1, 100, to);
    n_vec++;
    if (to) begin
      n_err++; $display("FAIL parity_timeout: got 0 frames, required 1");
    end else begin
      got = rx_q.pop_front(); void'(rx_start_q.pop_front());
      n_vec++;
      if (got[8:1] !== 8'h07) begin
        n_err++; $display("FAIL parity_data: got %h, required 07", got[8:1]);
      end
`ifdef UART_TX_PARITY_EN
      n_vec++;
      if (got[9] !== 1'b1) begin n_err++; $display("FAIL parity_bit: got %b, required 1", got[9]); end
`endif
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int s, n0, bad;
    bus_write(Base, 32'h30);
    s = last_wr + 2;
    bus_write(Base, 32'h31);
    bus_write(Base, 32'h32);
    while (cyc < s + 17) @(negedge clk);
    n_vec++;
    if (tx !== 1'b0) begin n_err++; $display("FAIL mid_bit3: got %b, required 0", tx); end
    reset = 1'b1;
    #1;
    n_vec++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL mid_reset_tx: got %b, required 1", tx); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(Stat, r);
    n_vec++;
    if (r !== (32'h4 | Par)) begin
      n_err++; $display("FAIL mid_status: got %h, required %h", r, 32'h4 | Par);
    end
    n0 = n_starts;
    bad = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    n_vec++;
    if (n_starts != n0 || rx_q.size() != 0 || bad != 0) begin
      n_err++;
      $display("FAIL mid_no_frames: got %0d starts %0d frames %0d low cycles, required 0 0 0",
               n_starts - n0, rx_q.size(), bad);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_on_pop();
    test_parity();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
